// File: rtl/decryptor_if.sv
// Request/result bundle for the 10-round block decryptor.
// The master drives the request side and the slave returns the result.
interface decryptor_if;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  modport master (
    output start, ciphertext, key,
    input  plaintext, done, busy
  );

  modport slave (
    input  start, ciphertext, key,
    output plaintext, done, busy
  );
endinterface

// File: rtl/decryptor.sv
// Iterative 128-bit decryptor: applies the inverse rounds 9..0, one per clock.
// It then presents the result with a one-cycle done pulse.
module decryptor (
  input  logic       clk,
  input  logic       rst,
  decryptor_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'd9;

  logic [1:0]   state_q, state_d;
  logic [127:0] s_q, s_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [127:0] round_s;

  // A shift by 128 yields zero, so a zero rotate amount needs no special case.
  function automatic logic [127:0] rotl128(input logic [127:0] x, input logic [7:0] sh);
    rotl128 = (x << sh) | (x >> (8'd128 - sh));
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input logic [3:0] i);
    round_key = rotl128(k, {1'b0, i, 3'b000}) ^ {124'd0, i};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk);
    logic [127:0] diff;
    diff      = s - rk;
    inv_round = {diff[4:0], diff[127:5]} ^ rk;
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    done_d  = done_q;
    busy_d  = busy_q;
    round_s = inv_round(s_q, round_key(key_q, cnt_q));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d     = bus.ciphertext;
          key_d   = bus.key;
          cnt_d   = LAST_ROUND;
          busy_d  = 1'b1;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        s_d = round_s;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pt_d    = round_s;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 128'd0;
      key_q   <= 128'd0;
      cnt_q   <= 4'd0;
      pt_q    <= 128'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.plaintext = pt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_decryptor.sv
// Directed and randomized checks of decryptor against a loop-based cipher model.
module tb_decryptor;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  decryptor_if bus ();

  decryptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] m_rotl(input logic [127:0] x, input int n);
    int r;
    r = n % 128;
    if (r == 0) return x;
    return (x << r) | (x >> (128 - r));
  endfunction

  function automatic logic [127:0] m_rk(input logic [127:0] k, input int i);
    return m_rotl(k, 8 * i) ^ 128'(i);
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s;
    s = p;
    for (int i = 0; i < 10; i++) s = m_rotl(s ^ m_rk(k, i), 5) + m_rk(k, i);
    return s;
  endfunction

  function automatic logic [127:0] m_dec(input logic [127:0] c, input logic [127:0] k);
    logic [127:0] s;
    s = c;
    for (int i = 9; i >= 0; i--) s = m_rotl(s - m_rk(k, i), 123) ^ m_rk(k, i);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one block, then follow it to done with a bounded wait.
  task automatic run_dec(input string tag, input logic [127:0] ct, input logic [127:0] k,
                         input bit scramble);
    int n;
    int busy_cnt;
    bus.ciphertext = ct;
    bus.key        = k;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    n         = 0;
    busy_cnt  = bus.busy ? 1 : 0;
    while (!bus.done && n < 20) begin
      if (scramble) begin
        bus.ciphertext = rnd128();
        bus.key        = rnd128();
      end
      tick();
      n++;
      if (bus.busy) busy_cnt++;
      chk({tag, "_done_and_busy"}, 128'(bus.done & bus.busy), 128'd0);
    end
    chk({tag, "_latency"}, 128'(n), 128'd10);
    chk({tag, "_busy_cycles"}, 128'(busy_cnt), 128'd10);
    chk({tag, "_plaintext"}, bus.plaintext, m_dec(ct, k));
    tick();
    chk({tag, "_done_pulse_width"}, 128'(bus.done), 128'd0);
  endtask

  initial begin
    logic [127:0] c1;
    logic [127:0] c2;
    logic [127:0] k1;
    logic [127:0] ct_log [0:63];
    logic [127:0] key_log [0:63];
    int           dones;
    int           acc_cnt;
    int           last_acc;
    bit           prev_busy;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.ciphertext = 128'd0;
    bus.key        = 128'd0;

    // Reset values
    tick();
    tick();
    chk("reset_plaintext", bus.plaintext, 128'd0);
    chk("reset_done", 128'(bus.done), 128'd0);
    chk("reset_busy", 128'(bus.busy), 128'd0);
    rst = 1'b0;

    // Zero vector: the round-index XOR makes the result nonzero
    run_dec("zero", 128'd0, 128'd0, 1'b0);
    chk("zero_nonzero", 128'(bus.plaintext != 128'd0), 128'd1);

    // Round trips through the model encryptor
    run_dec("rt1", m_enc(128'd1407, 128'd25), 128'd25, 1'b0);
    chk("rt1_value", bus.plaintext, 128'd1407);
    run_dec("rt2", m_enc(128'd285, 128'd1293), 128'd1293, 1'b1);
    chk("rt2_value", bus.plaintext, 128'd285);

    // Random vectors with input scrambling after acceptance
    for (int i = 0; i < 4; i++) run_dec("rand", rnd128(), rnd128(), 1'b1);

    // Ignore-while-busy
    c1 = rnd128();
    c2 = rnd128();
    k1 = rnd128();
    bus.ciphertext = c1;
    bus.key        = k1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    dones     = 0;
    for (int e = 1; e <= 25; e++) begin
      if (e == 4) begin
        bus.ciphertext = c2;
        bus.start      = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done) begin
        dones++;
        chk("ignore_latency", 128'(e), 128'd10);
        chk("ignore_plaintext", bus.plaintext, m_dec(c1, k1));
      end
    end
    bus.start = 1'b0;
    chk("ignore_single_done", 128'(dones), 128'd1);

    // Reset mid-operation
    bus.ciphertext = rnd128();
    bus.key        = rnd128();
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    rst   = 1'b1;
    dones = 0;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("midrst_plaintext", bus.plaintext, 128'd0);
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_no_done", 128'(dones), 128'd0);
    rst = 1'b0;
    run_dec("after_rst", rnd128(), rnd128(), 1'b0);

    // Back-to-back: start held high, inputs changing every cycle
    acc_cnt   = 0;
    dones     = 0;
    last_acc  = 0;
    prev_busy = bus.busy;
    for (int e = 0; e < 48; e++) begin
      ct_log[e]      = rnd128();
      key_log[e]     = rnd128();
      bus.ciphertext = ct_log[e];
      bus.key        = key_log[e];
      bus.start      = 1'b1;
      tick();
      if (bus.busy && !prev_busy) begin
        if (acc_cnt > 0) chk("b2b_spacing", 128'(e - last_acc), 128'd12);
        last_acc = e;
        acc_cnt++;
      end
      if (bus.done) begin
        dones++;
        chk("b2b_latency", 128'(e - last_acc), 128'd10);
        chk("b2b_plaintext", bus.plaintext, m_dec(ct_log[last_acc], key_log[last_acc]));
      end
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    chk("b2b_acceptances", 128'(acc_cnt), 128'd4);
    chk("b2b_dones", 128'(dones), 128'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decryptor.md
DECRYPTOR -- requirements
Module: decryptor

Interface
REQ-001 The block SHALL use one clock, clk; reset is rst, synchronous and active-high; all state changes occur on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 ciphertext  input  128  block to decrypt; captured on the accepting edge.
REQ-006 key  input  128  cipher key; captured on the accepting edge.
REQ-007 plaintext  output  128  registered result; valid while done=1; holds until the next acceptance or reset.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 busy  output  1  high from the cycle after acceptance until the cycle before done (ROUND state).

Function
REQ-010 Cipher definition, shared with encryptor, all arithmetic mod 2^128:
- round key rk_i = rotl128(key, 8*i) XOR {120'b0, i[7:0]}, for i = 0..9
- encrypt round: s' = rotl128(s XOR rk_i, 5) + rk_i
- decrypt round: s = rotr128(s' - rk_i, 5) XOR rk_i
REQ-011 Decryption SHALL apply inverse rounds i = 9, 8, ..., 0 in that order, one round per clock.
REQ-012 FSM states SHALL be IDLE, ROUND, FIN.
REQ-013 In IDLE with start=1 at an edge, the block SHALL:
- capture ciphertext into state register s and key into key register
- set round counter cnt=9
- go to ROUND
REQ-014 In ROUND, each edge SHALL replace s with the inverse round using rk_cnt, then:
- if cnt>0: decrement cnt
- if cnt=0: load plaintext with the result, set done=1, go to FIN
REQ-015 In FIN, the next edge SHALL clear done and go to IDLE; FIN lasts exactly one cycle.
REQ-016 Latency: done SHALL be high in the cycle beginning 10 edges after the accepting edge. Minimum start-to-start spacing is 12 cycles.
REQ-017 start while in ROUND or FIN SHALL be ignored, with no effect on s, key register, cnt, or outputs.
REQ-018 Changes on ciphertext or key after acceptance SHALL NOT affect the result in progress.
REQ-019 busy SHALL equal (state==ROUND); done and busy SHALL never be high together.
REQ-020 The round counter is 4 bits wide; no value outside 0..9 SHALL be reachable.

Reset
REQ-021 rst=1 at an edge SHALL force state=IDLE, plaintext=0, done=0, busy=0, cnt=0, s=0, key register=0, overriding start and any operation in progress.
REQ-022 rst asserted mid-ROUND SHALL abort with no done pulse; start is accepted on the first edge with rst=0.
REQ-023 While rst=1, start SHALL be ignored.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Reset values: hold rst=1 for 2 cycles -> plaintext=0, done=0, busy=0.
- Zero vector: key=0, ciphertext=0, start pulse -> done exactly 10 edges later; plaintext = bench-model decrypt of 0 (nonzero, because of the i-XOR terms); busy high for 10 cycles.
- Round trip: key=128'd25, plaintext P=128'd1407 encrypted by the bench model to C; decrypt C -> plaintext=128'd1407. Repeat with key=128'd1293, P=128'd285 -> 128'd285.
- Ignore-while-busy: start a decrypt, pulse start with different ciphertext at round 4 -> single done; result matches the first ciphertext; no second done.
- Reset mid-operation: assert rst at round 5 -> done never pulses, outputs 0. Deassert, start a new vector -> correct result 10 edges after acceptance.
- Back-to-back: hold start=1 continuously -> acceptances exactly 12 cycles apart; each result is correct; input changes after acceptance have no effect.
